// File: rtl/arm_pkg.sv
// Shared definitions for the multicycle ARM control unit: FSM states,
// ALU control codes, condition codes and the data-processing command decode.
package arm_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Unsupported commands fall back to ADD so the ALU always has a defined op.
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    logic [1:0] alu;
    case (cmd)
      CMD_ADD: alu = ALU_ADD;
      CMD_SUB: alu = ALU_SUB;
      CMD_AND: alu = ALU_AND;
      CMD_ORR: alu = ALU_ORR;
      default: alu = ALU_ADD;
    endcase
    return alu;
  endfunction

endpackage

// File: rtl/condition_check.sv
// Holds the NZCV flags, evaluates the instruction condition against them and
// registers the result at the end of DECODE for use by later states.
module condition_check
  import arm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic       cond_latch_i,
  input  logic       flag_write_i,
  input  logic       arith_op_i,
  output logic       cond_ex_o
);

  logic [3:0] nzcv_q, nzcv_d;
  logic       cond_ex_q, cond_ex_d;
  logic       cond_now;
  logic       n_s, z_s, c_s, v_s;

  assign n_s = nzcv_q[3];
  assign z_s = nzcv_q[2];
  assign c_s = nzcv_q[1];
  assign v_s = nzcv_q[0];

  // Condition evaluation against the stored flags; 1111 never executes.
  always_comb begin
    cond_now = 1'b0;
    case (cond_i)
      COND_EQ: cond_now = z_s;
      COND_NE: cond_now = ~z_s;
      COND_CS: cond_now = c_s;
      COND_CC: cond_now = ~c_s;
      COND_MI: cond_now = n_s;
      COND_PL: cond_now = ~n_s;
      COND_VS: cond_now = v_s;
      COND_VC: cond_now = ~v_s;
      COND_HI: cond_now = c_s & ~z_s;
      COND_LS: cond_now = ~c_s | z_s;
      COND_GE: cond_now = (n_s == v_s);
      COND_LT: cond_now = (n_s != v_s);
      COND_GT: cond_now = ~z_s & (n_s == v_s);
      COND_LE: cond_now = z_s | (n_s != v_s);
      COND_AL: cond_now = 1'b1;
      default: cond_now = 1'b0;
    endcase
  end

  // Next-state for the condition latch and the flag register.
  always_comb begin
    cond_ex_d = cond_ex_q;
    nzcv_d    = nzcv_q;
    if (cond_latch_i) begin
      cond_ex_d = cond_now;
    end else begin
      cond_ex_d = cond_ex_q;
    end
    if (flag_write_i && cond_ex_q) begin
      nzcv_d[3:2] = alu_flags_i[3:2];
      if (arith_op_i) begin
        nzcv_d[1:0] = alu_flags_i[1:0];
      end else begin
        nzcv_d[1:0] = nzcv_q[1:0];
      end
    end else begin
      nzcv_d = nzcv_q;
    end
  end

  // Flag and condition registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      nzcv_q    <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      nzcv_q    <= nzcv_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign cond_ex_o = cond_ex_q;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle ARM control FSM: sequences fetch/decode/execute states and
// drives datapath selects and write strobes gated by the condition result.
module multicycle_control_unit
  import arm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  output logic       pc_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       alu_src_a,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [1:0] alu_control
);

  state_e     state_q, state_d;
  logic       cond_ex_q;
  logic       regw_state;
  logic       is_exec;
  logic [1:0] alu_cmd;

  assign alu_cmd = alu_decode(funct[4:1]);
  assign is_exec = (state_q == EXECR) || (state_q == EXECI);

  condition_check u_cond (
    .clk          (clk),
    .reset        (reset),
    .cond_i       (cond),
    .alu_flags_i  (alu_flags),
    .cond_latch_i (state_q == DECODE),
    .flag_write_i (is_exec && funct[0]),
    .arith_op_i   ((alu_cmd == ALU_ADD) || (alu_cmd == ALU_SUB)),
    .cond_ex_o    (cond_ex_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_MEM:  state_d = MEMADR;
          OP_DP:   state_d = funct[5] ? EXECI : EXECR;
          OP_BR:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: state_d = funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXECR:  state_d = ALUWB;
      EXECI:  state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end

  // Datapath selects and strobes decoded from the current state.
  always_comb begin
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = ALU_ADD;
    regw_state  = 1'b0;
    mem_write   = 1'b0;
    case (state_q)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      MEMADR: alu_src_b = 2'b01;
      MEMRD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        regw_state = 1'b1;
      end
      MEMWR: begin
        adr_src   = 1'b1;
        mem_write = cond_ex_q;
      end
      EXECR:  alu_control = alu_cmd;
      EXECI: begin
        alu_src_b   = 2'b01;
        alu_control = alu_cmd;
      end
      ALUWB:  regw_state = 1'b1;
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
      end
      default: ir_write = 1'b0;
    endcase
  end

  // A write-back to R15 doubles as a jump, so it also raises pc_write.
  assign reg_write = regw_state & cond_ex_q;
  assign pc_write  = (state_q == FETCH)
                   | (cond_ex_q & ((state_q == BRANCH) | (regw_state & (rd == 4'd15))));

  assign imm_src = op;
  assign reg_src = {op == OP_MEM, op == OP_BR};

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench: a path/flag reference model predicts every
// output of every cycle of each instruction.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cond, rd, alu_flags;
  logic [1:0] op;
  logic [5:0] funct;
  logic       pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a;
  logic [1:0] result_src, alu_src_b, imm_src, reg_src, alu_control;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [3:0] m_nzcv;
  logic [4:0] force_flags;
  logic [15:0] obs;

  localparam int PH_F = 0, PH_D = 1, PH_MA = 2, PH_MR = 3, PH_MWB = 4,
                 PH_MW = 5, PH_ER = 6, PH_EI = 7, PH_AW = 8, PH_BR = 9;
  string ph_name[10] = '{"FETCH", "DECODE", "MEMADR", "MEMRD", "MEMWB",
                         "MEMWR", "EXECR", "EXECI", "ALUWB", "BRANCH"};

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk         (clk),
    .reset       (reset),
    .cond        (cond),
    .op          (op),
    .funct       (funct),
    .rd          (rd),
    .alu_flags   (alu_flags),
    .pc_write    (pc_write),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .ir_write    (ir_write),
    .adr_src     (adr_src),
    .alu_src_a   (alu_src_a),
    .result_src  (result_src),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .reg_src     (reg_src),
    .alu_control (alu_control)
  );

  assign obs = {pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a,
                result_src, alu_src_b, imm_src, reg_src, alu_control};

  task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (pc,mw,rw,ir,adr,asa,rs,bsel,imm,rsrc,alu)",
               tag, got, exp);
    end
  endtask

  // ARM condition semantics over a flag value.
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 2'b00;
      4'b0010: return 2'b01;
      4'b0000: return 2'b10;
      4'b1100: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Runs one instruction; rst_at is the path index at which reset is held high (-1: none).
  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] fn,
                           input logic [3:0] r, input int rst_at);
    int   path[$];
    bit   cex, arith;
    logic [3:0] af;
    logic pcw, mw, rw, irw, adr, asa;
    logic [1:0] rs, bs, alu;
    path = '{PH_F, PH_D};
    case (o)
      2'b01: begin
        path.push_back(PH_MA);
        if (fn[0]) begin path.push_back(PH_MR); path.push_back(PH_MWB); end
        else path.push_back(PH_MW);
      end
      2'b00: begin path.push_back(fn[5] ? PH_EI : PH_ER); path.push_back(PH_AW); end
      2'b10: path.push_back(PH_BR);
      default: ;
    endcase
    cex   = cond_holds(c, m_nzcv);
    arith = !((fn[4:1] == 4'b0000) || (fn[4:1] == 4'b1100));
    foreach (path[i]) begin
      af = force_flags[4] ? force_flags[3:0] : 4'($urandom);
      cond = c; op = o; funct = fn; rd = r; alu_flags = af;
      reset = (i == rst_at);
      #4;
      pcw = 0; mw = 0; rw = 0; irw = 0; adr = 0; asa = 0; rs = 2'b00; bs = 2'b00; alu = 2'b00;
      case (path[i])
        PH_F:   begin irw = 1; asa = 1; bs = 2'b10; rs = 2'b10; pcw = 1; end
        PH_D:   begin asa = 1; bs = 2'b10; rs = 2'b10; end
        PH_MA:  bs = 2'b01;
        PH_MR:  adr = 1;
        PH_MWB: begin rs = 2'b01; rw = cex; pcw = cex && (r == 4'd15); end
        PH_MW:  begin adr = 1; mw = cex; end
        PH_ER:  alu = alu_of(fn[4:1]);
        PH_EI:  begin bs = 2'b01; alu = alu_of(fn[4:1]); end
        PH_AW:  begin rw = cex; pcw = cex && (r == 4'd15); end
        PH_BR:  begin bs = 2'b01; rs = 2'b10; pcw = cex; end
        default: ;
      endcase
      check_vec(ph_name[path[i]], obs,
                {pcw, mw, rw, irw, adr, asa, rs, bs, o, (o == 2'b01), (o == 2'b10), alu});
      if (i == rst_at) begin
        m_nzcv = 4'b0000;
        @(posedge clk); #1;
        return;
      end
      if ((path[i] == PH_ER || path[i] == PH_EI) && fn[0] && cex) begin
        m_nzcv[3:2] = af[3:2];
        if (arith) m_nzcv[1:0] = af[1:0];
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; cond = 4'd0; op = 2'd0; funct = 6'd0; rd = 4'd0; alu_flags = 4'd0;
    force_flags = 5'd0; m_nzcv = 4'd0;
    @(posedge clk); #1;
    #4 check_vec("reset_fetch", obs, 16'h9680);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(4'he, 2'b00, 6'b001000, 4'd1, -1);   // ADD R1,R2,R3
    run_instr(4'he, 2'b01, 6'b011001, 4'd2, -1);   // LDR
    run_instr(4'he, 2'b01, 6'b011000, 4'd3, -1);   // STR
    force_flags = 5'h14;
    run_instr(4'he, 2'b00, 6'b000101, 4'd4, -1);   // SUBS -> Z=1
    force_flags = 5'h00;
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, -1);   // BEQ taken
    run_instr(4'h1, 2'b10, 6'b000000, 4'd0, -1);   // BNE not taken
    run_instr(4'he, 2'b00, 6'b001000, 4'd15, -1);  // ADD PC
    force_flags = 5'h10;
    run_instr(4'hf, 2'b00, 6'b001001, 4'd15, -1);  // never-condition ADDS
    force_flags = 5'h00;
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, -1);   // BEQ still taken
    run_instr(4'he, 2'b01, 6'b011001, 4'd2, 3);    // LDR, reset in MEMRD
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, -1);   // BEQ not taken after reset
    run_instr(4'h1, 2'b10, 6'b000000, 4'd0, -1);   // BNE taken
    run_instr(4'he, 2'b11, 6'b111111, 4'd15, -1);  // undefined op
    force_flags = 5'h13;
    run_instr(4'he, 2'b00, 6'b001001, 4'd5, -1);   // ADDS -> C,V
    force_flags = 5'h1c;
    run_instr(4'he, 2'b00, 6'b000001, 4'd6, -1);   // ANDS -> N,Z only
    force_flags = 5'h00;
    run_instr(4'h2, 2'b10, 6'b000000, 4'd0, -1);   // BCS
    run_instr(4'h6, 2'b10, 6'b000000, 4'd0, -1);   // BVS
    run_instr(4'h4, 2'b10, 6'b000000, 4'd0, -1);   // BMI

    for (int k = 0; k < 400; k++) begin
      int ra;
      ra = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(4'($urandom), 2'($urandom), 6'($urandom), 4'($urandom), ra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
